deser_fifo: RTL and testbench

Serial-to-parallel receiver with integrated word queue, parametrised in word width, queue depth, tick rates and bit order. Bits arrive on `data_in` qualified by `write_in`, are assembled into `DATA_W`-bit words and pushed into a `DEPTH`-entry circular FIFO that is drained by `dequeue_in`. Everything runs in the single `clock1M` domain. The two rates, 100 kHz for the deserializer and 10 kHz for the dequeue side, are clock enables, not derived clocks.

---
 rtl/deser_fifo_pkg.sv | 20 ++
 rtl/deser_fifo_if.sv | 25 ++
 rtl/deser_fifo_clk_en_div.sv | 32 +++
 rtl/deser_fifo.sv | 157 +++++++++++++++
 tb/tb_deser_fifo.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/deser_fifo_pkg.sv
// Shared types, default parameters and helpers for the deser_fifo serial receiver.
package deser_fifo_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int DEPTH_DEF     = 8;
  localparam int DES_DIV_DEF   = 10;
  localparam int FIFO_DIV_DEF  = 100;
  localparam int MSB_FIRST_DEF = 1;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  // Even parity bit over a word; zero-extension does not change the result.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/deser_fifo_if.sv
// Bus bundle between the serial source / queue consumer and deser_fifo.
interface deser_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  logic                       data_in;
  logic                       write_in;
  logic                       dequeue_in;
  logic [DATA_W-1:0]          data_out;
  logic                       data_valid;
  logic [$clog2(DEPTH+1)-1:0] len_out;
  logic                       status_out;
  logic                       overflow_out;
  logic                       parity_err_out;

  modport slave (
    input  data_in, write_in, dequeue_in,
    output data_out, data_valid, len_out, status_out, overflow_out, parity_err_out
  );

  modport master (
    output data_in, write_in, dequeue_in,
    input  data_out, data_valid, len_out, status_out, overflow_out, parity_err_out
  );
endinterface

// File: rtl/deser_fifo_clk_en_div.sv
// Free-running clock-enable divider: tick is high for one cycle every DIV cycles (DIV >= 2).
module clk_en_div #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // Registered tick lines up with cnt_r == DIV-1, first in cycle DIV-1 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      if (cnt_r == LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1'b1);
      end
      tick_r <= (cnt_r == PRE);
    end
  end

  assign tick = tick_r;
endmodule

// File: rtl/deser_fifo.sv
// Serial-to-parallel receiver feeding a circular word FIFO, single clock1M domain.
// Optional even-parity bit per word is enabled by defining DESER_FIFO_PARITY_EN.
module deser_fifo
  import deser_fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int DES_DIV   = DES_DIV_DEF,
  parameter int FIFO_DIV  = FIFO_DIV_DEF,
  parameter int MSB_FIRST = MSB_FIRST_DEF
) (
  input  logic         clock1M,
  input  logic         reset,
  deser_fifo_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [LW-1:0] FULL_LEN = LW'(DEPTH);
`ifdef DESER_FIFO_PARITY_EN
  localparam logic [CW-1:0] PAR_BIT  = CW'(DATA_W);
`else
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
`endif

  logic              des_tick_s, fifo_tick_s;
  state_t            state_r;
  logic [CW-1:0]     bit_cnt_r;
  logic [DATA_W-1:0] shift_r, word_r, shifted_s;
  logic              overflow_r;
`ifdef DESER_FIFO_PARITY_EN
  logic              parity_err_r;
`endif
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]     len_r;
  logic [DATA_W-1:0] data_out_r;
  logic              data_valid_r;
  logic              bit_ok_s, full_s, enq_s, pop_s;

  clk_en_div #(.DIV(DES_DIV))  u_des_div  (.clk(clock1M), .rst_n(reset), .tick(des_tick_s));
  clk_en_div #(.DIV(FIFO_DIV)) u_fifo_div (.clk(clock1M), .rst_n(reset), .tick(fifo_tick_s));

  // Shift direction, handshake qualifiers and FIFO full/empty decisions.
  always_comb begin
    shifted_s = shift_r;
    if (MSB_FIRST != 0) begin
      shifted_s = {shift_r[DATA_W-2:0], bus.data_in};
    end else begin
      shifted_s = {bus.data_in, shift_r[DATA_W-1:1]};
    end
    bit_ok_s = des_tick_s & bus.write_in;
    full_s   = (len_r == FULL_LEN);
    enq_s    = (state_r == ST_HOLD) && !full_s;
    pop_s    = fifo_tick_s && bus.dequeue_in && (len_r != '0);
  end

  // Deserializer FSM: collect bits into a word, then hold it until the FIFO has room.
  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_COLLECT;
      bit_cnt_r    <= '0;
      shift_r      <= '0;
      word_r       <= '0;
      overflow_r   <= 1'b0;
`ifdef DESER_FIFO_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
`ifdef DESER_FIFO_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      case (state_r)
        ST_COLLECT: begin
          if (bit_ok_s) begin
`ifdef DESER_FIFO_PARITY_EN
            if (bit_cnt_r == PAR_BIT) begin
              bit_cnt_r <= '0;
              if (bus.data_in == even_parity(64'(shift_r))) begin
                word_r  <= shift_r;
                state_r <= ST_HOLD;
              end else begin
                parity_err_r <= 1'b1;
              end
            end else begin
              shift_r   <= shifted_s;
              bit_cnt_r <= bit_cnt_r + CW'(1'b1);
            end
`else
            if (bit_cnt_r == LAST_BIT) begin
              word_r    <= shifted_s;
              bit_cnt_r <= '0;
              state_r   <= ST_HOLD;
            end else begin
              shift_r   <= shifted_s;
              bit_cnt_r <= bit_cnt_r + CW'(1'b1);
            end
`endif
          end
        end
        ST_HOLD: begin
          // A bit arriving while a word is parked has nowhere to go.
          if (bit_ok_s) begin
            overflow_r <= 1'b1;
          end
          if (enq_s) begin
            state_r <= ST_COLLECT;
          end
        end
        default: state_r <= ST_COLLECT;
      endcase
    end
  end

  // Storage array; contents are qualified by the pointers so it needs no reset.
  always_ff @(posedge clock1M) begin
    if (enq_s) begin
      mem[wr_ptr_r] <= word_r;
    end
  end

  // Pointers, occupancy and the registered pop result.
  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      len_r        <= '0;
      data_out_r   <= '0;
      data_valid_r <= 1'b0;
    end else begin
      data_valid_r <= pop_s;
      if (enq_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_s) begin
        data_out_r <= mem[rd_ptr_r];
        rd_ptr_r   <= rd_ptr_r + PW'(1'b1);
      end
      case ({enq_s, pop_s})
        2'b10:   len_r <= len_r + LW'(1'b1);
        2'b01:   len_r <= len_r - LW'(1'b1);
        default: len_r <= len_r;
      endcase
    end
  end

  assign bus.data_out     = data_out_r;
  assign bus.data_valid   = data_valid_r;
  assign bus.len_out      = len_r;
  assign bus.status_out   = (state_r == ST_HOLD);
  assign bus.overflow_out = overflow_r;
`ifdef DESER_FIFO_PARITY_EN
  assign bus.parity_err_out = parity_err_r;
`else
  assign bus.parity_err_out = 1'b0;
`endif
endmodule

// File: tb/tb_deser_fifo.sv
// Self-checking bench for deser_fifo: MSB-first and LSB-first instances driven in lockstep.
`timescale 1ns/1ps
module tb_deser_fifo;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 8;
  localparam int DES_DIV  = 10;
  localparam int FIFO_DIV = 100;

  logic clock1M = 1'b0;
  logic reset   = 1'b0;
  always #500 clock1M = ~clock1M;

  deser_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) if_m ();
  deser_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) if_l ();

  deser_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DES_DIV(DES_DIV), .FIFO_DIV(FIFO_DIV), .MSB_FIRST(1))
    dut_m (.clock1M(clock1M), .reset(reset), .bus(if_m.slave));
  deser_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DES_DIV(DES_DIV), .FIFO_DIV(FIFO_DIV), .MSB_FIRST(0))
    dut_l (.clock1M(clock1M), .reset(reset), .bus(if_l.slave));

  int checks = 0;
  int failures = 0;
  int vcnt_m = 0;
  int vcnt_l = 0;
  int pe_m = 0;
  int pe_l = 0;
  logic [7:0] sb_m[$];
  logic [7:0] sb_l[$];

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic drive(input logic d, input logic w, input logic q);
    if_m.data_in = d;    if_l.data_in = d;
    if_m.write_in = w;   if_l.write_in = w;
    if_m.dequeue_in = q; if_l.dequeue_in = q;
  endtask

  // One clock: sample at the falling edge, score any popped word.
  task automatic step();
    logic [7:0] e;
    @(negedge clock1M);
    if (if_m.data_valid) begin
      vcnt_m++;
      if (sb_m.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_m_unexpected_pop actual=%0h required=no_pop", if_m.data_out);
      end else begin
        e = sb_m.pop_front();
        check("sb_m_data", 32'(if_m.data_out), 32'(e));
      end
    end
    if (if_l.data_valid) begin
      vcnt_l++;
      if (sb_l.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_l_unexpected_pop actual=%0h required=no_pop", if_l.data_out);
      end else begin
        e = sb_l.pop_front();
        check("sb_l_data", 32'(if_l.data_out), 32'(e));
      end
    end
    if (if_m.parity_err_out) pe_m++;
    if (if_l.parity_err_out) pe_l++;
  endtask

  // Hold a bit for a full deserializer period: exactly one tick samples it.
  task automatic send_bit(input logic b);
    drive(b, 1'b1, 1'b0);
    repeat (DES_DIV) step();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_raw(input logic [7:0] w, input int gap_after);
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i]);
      if (i == gap_after) repeat (DES_DIV * 2) step();
    end
  endtask

  task automatic send_word(input logic [7:0] w, input logic [7:0] em, input logic [7:0] el, input int gap_after);
    send_raw(w, gap_after);
`ifdef DESER_FIFO_PARITY_EN
    send_bit(^w);
`endif
    sb_m.push_back(em);
    sb_l.push_back(el);
    repeat (2) step();
  endtask

  task automatic pop_one();
    drive(1'b0, 1'b0, 1'b1);
    repeat (FIFO_DIV) step();
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) step();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_m_data_out"}, 32'(if_m.data_out), 32'h0);
    check({tag, "_m_valid"},    32'(if_m.data_valid), 32'h0);
    check({tag, "_m_len"},      32'(if_m.len_out), 32'h0);
    check({tag, "_m_status"},   32'(if_m.status_out), 32'h0);
    check({tag, "_m_overflow"}, 32'(if_m.overflow_out), 32'h0);
    check({tag, "_m_parerr"},   32'(if_m.parity_err_out), 32'h0);
    check({tag, "_l_data_out"}, 32'(if_l.data_out), 32'h0);
    check({tag, "_l_len"},      32'(if_l.len_out), 32'h0);
    check({tag, "_l_overflow"}, 32'(if_l.overflow_out), 32'h0);
  endtask

  initial begin
    #(60_000_000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    logic found;
    logic [7:0] hold_m, hold_l;

    vecs[0] = '{word: 8'hA5, exp_m: 8'hA5, exp_l: 8'hA5};
    vecs[1] = '{word: 8'h80, exp_m: 8'h80, exp_l: 8'h01};
    vecs[2] = '{word: 8'h12, exp_m: 8'h12, exp_l: 8'h48};
    vecs[3] = '{word: 8'hF0, exp_m: 8'hF0, exp_l: 8'h0F};
    vecs[4] = '{word: 8'hC1, exp_m: 8'hC1, exp_l: 8'h83};

    drive(1'b0, 1'b0, 1'b0);
    repeat (3) step();
    check_zero("reset");
    reset = 1'b1;

    // Single words, each queued and popped.
    for (int i = 0; i < 5; i++) begin
      send_word(vecs[i].word, vecs[i].exp_m, vecs[i].exp_l, -1);
      check("vec_len_after_push", 32'(if_m.len_out), 32'd1);
      check("vec_status_after_push", 32'(if_m.status_out), 32'd0);
      v0 = vcnt_m;
      pop_one();
      check("vec_valid_pulses", 32'(vcnt_m - v0), 32'd1);
      check("vec_m_data_out", 32'(if_m.data_out), 32'(vecs[i].exp_m));
      check("vec_l_data_out", 32'(if_l.data_out), 32'(vecs[i].exp_l));
      check("vec_len_after_pop", 32'(if_m.len_out), 32'd0);
    end

    // Idle ticks in the middle of a word must not disturb it.
    send_word(8'h6B, 8'h6B, 8'hD6, 4);
    pop_one();
    check("gap_m_data_out", 32'(if_m.data_out), 32'h6B);
    check("gap_l_data_out", 32'(if_l.data_out), 32'hD6);

    // Fill, then park a ninth word and drop extra bits.
    for (int i = 0; i < 8; i++) send_word(8'(i), 8'(i), rev8(8'(i)), -1);
    check("full_len", 32'(if_m.len_out), 32'd8);
    check("full_status_before", 32'(if_m.status_out), 32'd0);
    send_word(8'h08, 8'h08, rev8(8'h08), -1);
    check("hold_status", 32'(if_m.status_out), 32'd1);
    check("hold_len", 32'(if_m.len_out), 32'd8);
    check("hold_overflow_clear", 32'(if_m.overflow_out), 32'd0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    check("overflow_m", 32'(if_m.overflow_out), 32'd1);
    check("overflow_l", 32'(if_l.overflow_out), 32'd1);

    // Pop from full: held word enqueues exactly one cycle later.
    v0 = vcnt_m;
    found = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < FIFO_DIV + 2 && !found; i++) begin
      step();
      if (vcnt_m != v0) found = 1'b1;
    end
    drive(1'b0, 1'b0, 1'b0);
    check("full_pop_seen", 32'(found), 32'd1);
    check("full_pop_len", 32'(if_m.len_out), 32'd7);
    check("full_pop_status", 32'(if_m.status_out), 32'd1);
    step();
    check("held_enq_len", 32'(if_m.len_out), 32'd8);
    check("held_enq_status", 32'(if_m.status_out), 32'd0);
    check("overflow_sticky", 32'(if_m.overflow_out), 32'd1);

    // Drain through pointer wrap-around.
    for (int i = 0; i < 4; i++) pop_one();
    for (int i = 9; i < 13; i++) send_word(8'(i), 8'(i), rev8(8'(i)), -1);
    check("wrap_len", 32'(if_m.len_out), 32'd8);
    for (int i = 0; i < 8; i++) pop_one();
    check("drain_len", 32'(if_m.len_out), 32'd0);
    check("drain_last_m", 32'(if_m.data_out), 32'h0C);
    check("drain_last_l", 32'(if_l.data_out), 32'h30);
    check("drain_sb_empty", 32'(sb_m.size() + sb_l.size()), 32'd0);

    // Pop while empty is ignored.
    v0 = vcnt_m;
    hold_m = if_m.data_out;
    hold_l = if_l.data_out;
    pop_one();
    check("empty_pop_no_valid", 32'(vcnt_m - v0), 32'd0);
    check("empty_pop_hold_m", 32'(if_m.data_out), 32'(hold_m));
    check("empty_pop_hold_l", 32'(if_l.data_out), 32'(hold_l));
    check("empty_pop_len", 32'(if_m.len_out), 32'd0);

    // Reset mid-word discards partial bits and sticky flags.
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    reset = 1'b0;
    repeat (3) step();
    check_zero("midreset");
    sb_m.delete();
    sb_l.delete();
    reset = 1'b1;
    step();
    send_word(8'h35, 8'h35, 8'hAC, -1);
    check("post_reset_len", 32'(if_m.len_out), 32'd1);
    pop_one();
    check("post_reset_m", 32'(if_m.data_out), 32'h35);
    check("post_reset_l", 32'(if_l.data_out), 32'hAC);

`ifdef DESER_FIFO_PARITY_EN
    send_word(8'hA5, 8'hA5, 8'hA5, -1);
    check("par_good_len", 32'(if_m.len_out), 32'd1);
    check("par_good_no_err", 32'(pe_m), 32'd0);
    send_raw(8'hA5, -1);
    send_bit(1'b1);
    repeat (2) step();
    check("par_bad_pulse_m", 32'(pe_m), 32'd1);
    check("par_bad_pulse_l", 32'(pe_l), 32'd1);
    check("par_bad_len", 32'(if_m.len_out), 32'd1);
    check("par_bad_status", 32'(if_m.status_out), 32'd0);
    pop_one();
    check("par_pop_data", 32'(if_m.data_out), 32'hA5);
`else
    check("parity_err_never_m", 32'(pe_m), 32'd0);
    check("parity_err_never_l", 32'(pe_l), 32'd0);
`endif
    check("final_sb_empty", 32'(sb_m.size() + sb_l.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
